pipeline_sequencer: RTL
=======================

# pipeline_sequencer

Central stall/flush/halt controller for the 5-stage RISC-V core. It merges the hazard-detector bubble request, the EX-stage taken-branch signal and the data-memory wait handshake into one set of per-stage register enables, bubble selects and flush strobes. It also sequences a debug halt: it drains the pipeline, parks the core, and resumes it. Sits in Stage 2 beside the hazard unit; its outputs drive the PC register, the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the ID/EX control mux.

## Interface
- DRAIN_CYCLES, 3: bubble-injection cycles needed to empty ID/EX..MEM/WB before halting.
- MEM_TIMEOUT, 15: maximum consecutive wait cycles on a data-memory access before an error halt.
- CNT_W, 16: width of the performance counters.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset).
- hz_stall  in  1  bubble request from the hazard detector (load-use / branch-operand hazard).
- br_taken  in  1  branch resolved taken in EX this cycle.
- dmem_req  in  1  MEM stage issues a load or store this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  debug halt request (level).
- resume  in  1  debug resume pulse.
- cnt_clr  in  1  clears both performance counters.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush  out  1  loads NOP into IF/ID.
- id_ex_bubble  out  1  selects zeroed control into ID/EX (hazard mux select).
- mem_wb_bubble  out  1  loads NOP into MEM/WB.
- halted  out  1  core parked.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_en=0 in RUN/MEMWAIT, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

## Operation
- **State register:** RUN, MEMWAIT, DRAIN, HALTED. The enables, bubbles and flush strobe are combinational (Mealy) outputs of the state and the current inputs.
- **Memory-stall condition:** mstall = dmem_req & ~dmem_ready.
- **RUN:** evaluate in priority order; the first match wins.
  1. mstall: all five enables = 0, mem_wb_bubble = 0. Go to MEMWAIT; wait_cnt <= 1.
  2. br_taken: all enables = 1, if_id_flush = 1, id_ex_bubble = 1. hz_stall is ignored (the instruction in ID is on the wrong path). flush_cnt++. If halt_req = 1, go to DRAIN; otherwise stay in RUN.
  3. hz_stall: pc_en = 0, if_id_en = 0, id_ex_bubble = 1, id_ex_en/ex_mem_en/mem_wb_en = 1.
  4. halt_req: pc_en = 0, if_id_en = 0, id_ex_bubble = 1, downstream enables = 1. Go to DRAIN; drain_cnt <= 1.
  5. Otherwise: all enables = 1, no bubbles.
- **MEMWAIT:**
  - dmem_ready = 0: everything frozen (all enables = 0); wait_cnt++. When wait_cnt = MEM_TIMEOUT, set mem_err = 1 and go to HALTED.
  - dmem_ready = 1: outputs are exactly as RUN evaluated without the mstall term (branch, hazard and halt rules apply). The next state follows the same rules; the default is RUN.
- **DRAIN:**
  - pc_en = 0, if_id_en = 0, id_ex_bubble = 1, id_ex_en/ex_mem_en/mem_wb_en = 1.
  - mstall freezes all enables and holds drain_cnt; the timeout rule above applies via wait_cnt.
  - br_taken during DRAIN: if_id_flush = 1, pc_en = 1 (the branch target is loaded), counted in flush_cnt.
  - When drain_cnt = DRAIN_CYCLES and there is no mstall, go to HALTED.
- **HALTED:** all enables = 0, halted = 1. A resume pulse with mem_err = 0 returns to RUN next cycle. resume is ignored when mem_err = 1; only reset clears mem_err.
- **Counters:**
  - Saturate at all-ones.
  - cnt_clr zeroes both counters and has priority over increment in the same cycle.
  - stall_cnt does not count DRAIN or HALTED cycles.
- **Reset (rst_n = 1), reset values:**
  - Registers: state = RUN, counters = 0, mem_err = 0, halted = 0.
  - Outputs while reset is held: all enables = 0, if_id_flush = 1, id_ex_bubble = 1, mem_wb_bubble = 1.
  - Reset mid-MEMWAIT or mid-DRAIN aborts the sequence.

## Timing
- Stall, flush and bubble outputs respond in the same cycle as their inputs (zero latency). State changes take effect on the next edge.
- A memory access answered N cycles after dmem_req freezes the pipeline for exactly N cycles; it resumes in the cycle dmem_ready = 1.
- halt_req asserted in cycle t with no other events: DRAIN during t+1..t+DRAIN_CYCLES, halted = 1 from t+DRAIN_CYCLES+1.
- A resume pulse in cycle h gives halted = 0 and pc_en = 1 in h+1.
- Timeout: with dmem_ready stuck at 0 from cycle t, mem_err = 1 and halted = 1 from t+MEM_TIMEOUT.

## Test plan
- **Hazard stall:** hz_stall = 1 for 1 cycle in RUN → pc_en = 0, if_id_en = 0, id_ex_bubble = 1 that cycle only; stall_cnt = 1.
- **Branch beats hazard:** br_taken = 1 and hz_stall = 1 together → pc_en = 1, if_id_flush = 1, id_ex_bubble = 1; flush_cnt = 1, stall_cnt = 0.
- **Memory wait:** dmem_req = 1, dmem_ready low for 3 cycles then high → all enables 0 for 3 cycles, all 1 on the 4th; stall_cnt = 3; state returns to RUN.
- **Timeout:** dmem_req = 1, dmem_ready held at 0 → mem_err = 1 and halted = 1 after 15 cycles; a later resume pulse has no effect; reset clears both.
- **Halt/resume:** halt_req in cycle 0 → id_ex_bubble = 1 for cycles 0-3 and halted = 1 at cycle 4. A mem stall injected at cycle 2 extends the drain by the stall length. resume → RUN and pc_en = 1 the next cycle.
- **Saturation/clear:** preload stall_cnt to 0xFFFF, then hold hz_stall → it stays at 0xFFFF. cnt_clr together with hz_stall → 0.

Source files
------------

// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline sequencer and the stages it drives.
// Carries hazard/branch/memory/debug requests in, enables and strobes out.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic hz_stall;
  logic br_taken;
  logic dmem_req;
  logic dmem_ready;
  logic halt_req;
  logic resume;
  logic cnt_clr;
  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_bubble;
  logic mem_wb_bubble;
  logic halted;
  logic mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hz_stall, br_taken, dmem_req, dmem_ready,
    output halt_req, resume, cnt_clr,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_bubble, mem_wb_bubble,
    input  halted, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  hz_stall, br_taken, dmem_req, dmem_ready,
    input  halt_req, resume, cnt_clr,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_bubble, mem_wb_bubble,
    output halted, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stall/flush/halt controller: merges hazard, branch and memory-wait
// requests into per-stage enables and sequences debug drain/halt/resume.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst_n,
  pipeline_sequencer_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

  state_t state, state_n;
  state_t r_next;
  logic [DW-1:0] drain_cnt, drain_cnt_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic mem_err, mem_err_n;
  logic halted_q;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mstall, frozen;
  logic stall_inc, flush_inc;
  logic [4:0] en, r_en;
  logic flush, bubble, wb_bubble;
  logic r_flush, r_bubble, r_flinc;

  assign mstall = bus.dmem_req & ~bus.dmem_ready;

  // Branch/hazard/halt priority, shared by RUN and a completing MEMWAIT
  always_comb begin
    r_en     = 5'b11111;
    r_flush  = 1'b0;
    r_bubble = 1'b0;
    r_flinc  = 1'b0;
    r_next   = RUN;
    if (bus.br_taken) begin
      r_flush  = 1'b1;
      r_bubble = 1'b1;
      r_flinc  = 1'b1;
      if (bus.halt_req) r_next = DRAIN;
    end else if (bus.hz_stall) begin
      r_en     = 5'b00111;
      r_bubble = 1'b1;
    end else if (bus.halt_req) begin
      r_en     = 5'b00111;
      r_bubble = 1'b1;
      r_next   = DRAIN;
    end
  end

  always_comb begin
    state_n     = state;
    en          = '0;
    flush       = 1'b0;
    bubble      = 1'b0;
    wb_bubble   = 1'b0;
    drain_cnt_n = drain_cnt;
    wait_cnt_n  = '0;
    mem_err_n   = mem_err;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    frozen      = 1'b0;
    unique case (state)
      RUN, MEMWAIT: begin
        if (state == RUN ? mstall : ~bus.dmem_ready) begin
          frozen    = 1'b1;
          stall_inc = 1'b1;
          state_n   = MEMWAIT;
        end else begin
          en        = r_en;
          flush     = r_flush;
          bubble    = r_bubble;
          flush_inc = r_flinc;
          stall_inc = ~r_en[4];
          state_n   = r_next;
          if (r_next == DRAIN) drain_cnt_n = DW'(1);
        end
      end
      DRAIN: begin
        bubble = 1'b1;
        if (mstall) begin
          frozen = 1'b1;
        end else begin
          en = 5'b00111;
          if (bus.br_taken) begin
            en[4]     = 1'b1;
            flush     = 1'b1;
            flush_inc = 1'b1;
          end
          if (drain_cnt == DW'(DRAIN_CYCLES)) state_n = HALTED;
          else drain_cnt_n = drain_cnt + 1'b1;
        end
      end
      HALTED: begin
        if (bus.resume && !mem_err) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
    // Consecutive memory-frozen cycles trip the timeout halt
    if (frozen) begin
      wait_cnt_n = wait_cnt + 1'b1;
      if (wait_cnt_n == WW'(MEM_TIMEOUT)) begin
        state_n   = HALTED;
        mem_err_n = 1'b1;
      end
    end
    if (rst_n) begin
      en        = '0;
      flush     = 1'b1;
      bubble    = 1'b1;
      wb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      halted_q  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
      wait_cnt  <= wait_cnt_n;
      mem_err   <= mem_err_n;
      halted_q  <= (state_n == HALTED);
      if (bus.cnt_clr) stall_cnt <= '0;
      else if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (bus.cnt_clr) flush_cnt <= '0;
      else if (flush_inc && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.pc_en         = en[4];
  assign bus.if_id_en      = en[3];
  assign bus.id_ex_en      = en[2];
  assign bus.ex_mem_en     = en[1];
  assign bus.mem_wb_en     = en[0];
  assign bus.if_id_flush   = flush;
  assign bus.id_ex_bubble  = bubble;
  assign bus.mem_wb_bubble = wb_bubble;
  assign bus.halted        = halted_q;
  assign bus.mem_err       = mem_err;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.flush_cnt     = flush_cnt;
endmodule
